// File: rtl/issue_scheduler_if.sv
// Decoder-to-scheduler handshake: decoded instruction fields plus the valid/ready pair.
interface issue_scheduler_if #(
    parameter int FUCOUNT = 5
);
    logic               InstrValid;
    logic               InstrReady;
    logic [3:0]         DecRegAAddr;
    logic               DecRegAReadEn;
    logic               DecRegAWriteEn;
    logic [3:0]         DecRegBAddr;
    logic               DecRegBReadEn;
    logic               DecDirtyBitTrigger;
    logic [FUCOUNT-1:0] DecFUEnable;
    logic               DecBranchStall;
    logic               DecHaltEn;

    modport master (
        output InstrValid, DecRegAAddr, DecRegAReadEn, DecRegAWriteEn,
               DecRegBAddr, DecRegBReadEn, DecDirtyBitTrigger,
               DecFUEnable, DecBranchStall, DecHaltEn,
        input  InstrReady
    );

    modport slave (
        input  InstrValid, DecRegAAddr, DecRegAReadEn, DecRegAWriteEn,
               DecRegBAddr, DecRegBReadEn, DecDirtyBitTrigger,
               DecFUEnable, DecBranchStall, DecHaltEn,
        output InstrReady
    );
endinterface

// File: rtl/issue_scheduler.sv
// Single-issue scheduler: dirty-bit scoreboard, FU-busy stall, branch hold and
// halt sequencing (drain outstanding writes, then stop until reset).
module issue_scheduler #(
    parameter int REGCOUNT      = 16,
    parameter int FUCOUNT       = 5,
    parameter int STALLCNTWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    issue_scheduler_if.slave         dec,
    input  logic [FUCOUNT-1:0]       FUReady,
    input  logic                     WritebackValid,
    input  logic [3:0]               WritebackAddr,
    input  logic                     BranchResolved,
    output logic                     IssueValid,
    output logic [FUCOUNT-1:0]       IssueFUEnable,
    output logic [REGCOUNT-1:0]      DirtyVector,
    output logic                     Halted,
    output logic [STALLCNTWIDTH-1:0] StallCycles
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        BRANCH_WAIT = 2'd1,
        DRAIN       = 2'd2,
        HALTED      = 2'd3
    } state_t;

    localparam logic [STALLCNTWIDTH-1:0] STALL_ONE = 1;

    state_t               state, state_next;
    logic [REGCOUNT-1:0]  wb_mask, eff_dirty, set_mask;
    logic                 hazard, fu_ok, ready, accept, issue, stall_event;

    // A same-cycle writeback already counts as clean, so a dependent instruction
    // issues without a bubble; a new set on the same bit still wins over that clear.
    always_comb begin
        wb_mask = '0;
        if (WritebackValid)
            wb_mask[WritebackAddr] = 1'b1;
        eff_dirty = DirtyVector & ~wb_mask;

        hazard = 1'b0;
        if (dec.DecRegAAddr != 4'd0 && eff_dirty[dec.DecRegAAddr] &&
            (dec.DecRegAReadEn || dec.DecRegAWriteEn))
            hazard = 1'b1;
        if (dec.DecRegBAddr != 4'd0 && eff_dirty[dec.DecRegBAddr] && dec.DecRegBReadEn)
            hazard = 1'b1;

        fu_ok  = (dec.DecFUEnable == '0) || (|(dec.DecFUEnable & FUReady));
        ready  = (state == RUN) && !hazard && fu_ok;
        accept = dec.InstrValid && ready;
        issue  = accept && !dec.DecHaltEn;

        set_mask = '0;
        if (issue && dec.DecDirtyBitTrigger && dec.DecRegAWriteEn && dec.DecRegAAddr != 4'd0)
            set_mask[dec.DecRegAAddr] = 1'b1;

        stall_event = dec.InstrValid && !ready && (state == RUN || state == BRANCH_WAIT);
    end

    // Halt outranks branch when a single instruction carries both flags.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (accept && dec.DecHaltEn)
                    state_next = DRAIN;
                else if (accept && dec.DecBranchStall)
                    state_next = BRANCH_WAIT;
            end
            BRANCH_WAIT: begin
                if (BranchResolved)
                    state_next = RUN;
            end
            DRAIN: begin
                if (eff_dirty == '0)
                    state_next = HALTED;
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= RUN;
            DirtyVector   <= '0;
            IssueValid    <= 1'b0;
            IssueFUEnable <= '0;
            StallCycles   <= '0;
        end else begin
            state         <= state_next;
            DirtyVector   <= eff_dirty | set_mask;
            IssueValid    <= issue;
            IssueFUEnable <= issue ? dec.DecFUEnable : '0;
            if (stall_event && StallCycles != '1)
                StallCycles <= StallCycles + STALL_ONE;
        end
    end

    assign dec.InstrReady = ready;
    assign Halted         = (state == HALTED);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler; a narrow stall counter keeps the saturation check short.
module tb_issue_scheduler;

    localparam int REGCOUNT      = 16;
    localparam int FUCOUNT       = 5;
    localparam int STALLCNTWIDTH = 6;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [FUCOUNT-1:0]       FUReady;
    logic                     WritebackValid;
    logic [3:0]               WritebackAddr;
    logic                     BranchResolved;
    logic                     IssueValid;
    logic [FUCOUNT-1:0]       IssueFUEnable;
    logic [REGCOUNT-1:0]      DirtyVector;
    logic                     Halted;
    logic [STALLCNTWIDTH-1:0] StallCycles;

    int checks = 0;
    int errors = 0;

    issue_scheduler_if #(.FUCOUNT(FUCOUNT)) dec_if ();

    issue_scheduler #(
        .REGCOUNT(REGCOUNT), .FUCOUNT(FUCOUNT), .STALLCNTWIDTH(STALLCNTWIDTH)
    ) dut (
        .clk(clk), .rst(rst), .dec(dec_if.slave), .FUReady(FUReady),
        .WritebackValid(WritebackValid), .WritebackAddr(WritebackAddr),
        .BranchResolved(BranchResolved), .IssueValid(IssueValid),
        .IssueFUEnable(IssueFUEnable), .DirtyVector(DirtyVector),
        .Halted(Halted), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] a_addr, input logic a_rd,
                                 input logic a_wr, input logic [3:0] b_addr, input logic b_rd,
                                 input logic dirty, input logic [4:0] fu, input logic br,
                                 input logic halt);
        dec_if.InstrValid         = valid;
        dec_if.DecRegAAddr        = a_addr;
        dec_if.DecRegAReadEn      = a_rd;
        dec_if.DecRegAWriteEn     = a_wr;
        dec_if.DecRegBAddr        = b_addr;
        dec_if.DecRegBReadEn      = b_rd;
        dec_if.DecDirtyBitTrigger = dirty;
        dec_if.DecFUEnable        = fu;
        dec_if.DecBranchStall     = br;
        dec_if.DecHaltEn          = halt;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writeback(input logic valid, input logic [3:0] addr);
        WritebackValid = valid;
        WritebackAddr  = addr;
    endtask

    task automatic doReset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic issueWrite(input logic [3:0] addr);
        applyStimulus(1'b1, addr, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        FUReady        = 5'b11111;
        BranchResolved = 1'b0;
        writeback(1'b0, 4'd0);
        idle();
        doReset();

        checkOutput("reset_dirty", 32'(DirtyVector), 32'h0);
        checkOutput("reset_issue_valid", 32'(IssueValid), 32'h0);
        checkOutput("reset_issue_fu", 32'(IssueFUEnable), 32'h0);
        checkOutput("reset_halted", 32'(Halted), 32'h0);
        checkOutput("reset_stall", 32'(StallCycles), 32'h0);

        // RAW dependency on r3, released by a same-cycle writeback
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
        checkOutput("dep_first_ready", 32'(dec_if.InstrReady), 32'h1);
        step();
        checkOutput("dep_first_issue", 32'(IssueValid), 32'h1);
        checkOutput("dep_first_fu", 32'(IssueFUEnable), 32'h01);
        checkOutput("dep_dirty_r3", 32'(DirtyVector), 32'h0008);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b0);
        checkOutput("dep_stall_ready", 32'(dec_if.InstrReady), 32'h0);
        for (int i = 0; i < 3; i++) step();
        checkOutput("dep_stall_no_issue", 32'(IssueValid), 32'h0);
        checkOutput("dep_stall_count", 32'(StallCycles), 32'd3);
        writeback(1'b1, 4'd3);
        #1;
        checkOutput("dep_wb_ready", 32'(dec_if.InstrReady), 32'h1);
        step();
        checkOutput("dep_second_issue", 32'(IssueValid), 32'h1);
        checkOutput("dep_second_fu", 32'(IssueFUEnable), 32'h02);
        checkOutput("dep_dirty_clear", 32'(DirtyVector), 32'h0000);
        checkOutput("dep_stall_hold", 32'(StallCycles), 32'd3);
        writeback(1'b0, 4'd0);

        // Same-cycle set and clear on r5; r0 never becomes dirty
        issueWrite(4'd5);
        checkOutput("r5_dirty", 32'(DirtyVector), 32'h0020);
        applyStimulus(1'b0, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
        checkOutput("waw_ready", 32'(dec_if.InstrReady), 32'h0);
        writeback(1'b1, 4'd5);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
        checkOutput("waw_wb_ready", 32'(dec_if.InstrReady), 32'h1);
        step();
        checkOutput("set_wins", 32'(DirtyVector), 32'h0020);
        idle();
        step();
        checkOutput("r5_cleared", 32'(DirtyVector), 32'h0000);
        writeback(1'b0, 4'd0);
        issueWrite(4'd0);
        checkOutput("r0_issue", 32'(IssueValid), 32'h1);
        checkOutput("r0_not_dirty", 32'(DirtyVector), 32'h0000);

        // Functional unit busy
        FUReady = 5'b10111;
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0);
        checkOutput("fu_busy_ready", 32'(dec_if.InstrReady), 32'h0);
        step();
        checkOutput("fu_busy_stall", 32'(StallCycles), 32'd4);
        FUReady = 5'b11111;
        #1;
        checkOutput("fu_free_ready", 32'(dec_if.InstrReady), 32'h1);
        step();
        checkOutput("fu_issue_fu", 32'(IssueFUEnable), 32'h08);
        FUReady = 5'b00000;
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
        checkOutput("no_fu_ready", 32'(dec_if.InstrReady), 32'h1);
        step();
        checkOutput("no_fu_issue", 32'(IssueValid), 32'h1);
        checkOutput("no_fu_enable", 32'(IssueFUEnable), 32'h00);
        FUReady = 5'b11111;

        // Branch hold
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b0);
        step();
        checkOutput("br_issue_fu", 32'(IssueFUEnable), 32'h10);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
        checkOutput("br_wait_ready", 32'(dec_if.InstrReady), 32'h0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("br_wait_no_issue", 32'(IssueValid), 32'h0);
        checkOutput("br_wait_stall", 32'(StallCycles), 32'd8);
        BranchResolved = 1'b1;
        #1;
        checkOutput("br_resolve_ready", 32'(dec_if.InstrReady), 32'h0);
        step();
        BranchResolved = 1'b0;
        #1;
        checkOutput("br_after_ready", 32'(dec_if.InstrReady), 32'h1);
        checkOutput("br_after_stall", 32'(StallCycles), 32'd9);
        step();
        checkOutput("br_after_issue", 32'(IssueValid), 32'h1);

        // Saturation while stalled on r2, then halt with r2 and r7 dirty
        issueWrite(4'd2);
        issueWrite(4'd7);
        checkOutput("halt_dirty_pre", 32'(DirtyVector), 32'h0084);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0);
        for (int i = 0; i < 54; i++) step();
        checkOutput("stall_reach_max", 32'(StallCycles), 32'd63);
        for (int i = 0; i < 6; i++) step();
        checkOutput("stall_saturate", 32'(StallCycles), 32'd63);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b1);
        checkOutput("halt_ready", 32'(dec_if.InstrReady), 32'h1);
        step();
        checkOutput("halt_no_issue", 32'(IssueValid), 32'h0);
        checkOutput("halt_no_fu", 32'(IssueFUEnable), 32'h00);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
        checkOutput("drain_ready", 32'(dec_if.InstrReady), 32'h0);
        writeback(1'b1, 4'd2);
        step();
        checkOutput("drain_dirty_r7", 32'(DirtyVector), 32'h0080);
        checkOutput("drain_not_halted", 32'(Halted), 32'h0);
        writeback(1'b1, 4'd7);
        step();
        checkOutput("halted_set", 32'(Halted), 32'h1);
        checkOutput("halted_dirty", 32'(DirtyVector), 32'h0000);
        writeback(1'b0, 4'd0);
        step();
        checkOutput("halted_sticky", 32'(Halted), 32'h1);
        checkOutput("halted_ready", 32'(dec_if.InstrReady), 32'h0);
        checkOutput("halted_no_issue", 32'(IssueValid), 32'h0);

        // Reset in the middle of a branch wait with r4..r7 dirty
        idle();
        doReset();
        issueWrite(4'd4);
        issueWrite(4'd5);
        issueWrite(4'd6);
        issueWrite(4'd7);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b0);
        step();
        checkOutput("mid_dirty", 32'(DirtyVector), 32'h00F0);
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
        checkOutput("mid_branch_ready", 32'(dec_if.InstrReady), 32'h0);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checkOutput("rst2_dirty", 32'(DirtyVector), 32'h0);
        checkOutput("rst2_issue", 32'(IssueValid), 32'h0);
        checkOutput("rst2_fu", 32'(IssueFUEnable), 32'h0);
        checkOutput("rst2_halted", 32'(Halted), 32'h0);
        checkOutput("rst2_stall", 32'(StallCycles), 32'h0);
        checkOutput("rst2_ready", 32'(dec_if.InstrReady), 32'h1);
        step();
        checkOutput("rst2_issue_after", 32'(IssueValid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Sits between the instruction decoder and the functional units (ALU0, ALU1, Complex, Memory, Branch).
- Keeps a 16-entry register dirty-bit scoreboard and stalls on RAW/WAW hazards and busy functional units.
- Holds issue while a branch is unresolved and sequences halt: drain outstanding writes, then stop.
- Issues at most one decoded instruction per cycle over a valid/ready handshake.

Parameters:
REGCOUNT, 16, number of architectural registers; r0 is never marked dirty.
FUCOUNT, 5, width of the one-hot functional-unit enable (b0 ALU0, b1 ALU1, b2 Complex, b3 Memory, b4 Branch).
STALLCNTWIDTH, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
InstrValid  in  1  decoded instruction present
InstrReady  out  1  scheduler accepts the instruction this cycle
DecRegAAddr  in  4  register A address
DecRegAReadEn  in  1  register A is a source
DecRegAWriteEn  in  1  register A is a destination
DecRegBAddr  in  4  register B address
DecRegBReadEn  in  1  register B is a source
DecDirtyBitTrigger  in  1  destination is written back later; mark dirty
DecFUEnable  in  FUCOUNT  one-hot target unit, or all zero for no unit
DecBranchStall  in  1  branch must resolve before next issue
DecHaltEn  in  1  halt instruction
FUReady  in  FUCOUNT  per-unit ready
WritebackValid  in  1  register writeback this cycle
WritebackAddr  in  4  writeback register, clears its dirty bit
BranchResolved  in  1  branch unit has resolved the pending branch
IssueValid  out  1  registered issue pulse
IssueFUEnable  out  FUCOUNT  registered copy of DecFUEnable for the issued instruction
DirtyVector  out  REGCOUNT  scoreboard state
Halted  out  1  scheduler is halted
StallCycles  out  STALLCNTWIDTH  saturating count of stalled cycles

Behaviour:
- Reset (rst=0 at clk edge): state RUN; DirtyVector, IssueValid, IssueFUEnable, Halted and StallCycles all 0. Applies mid-branch and mid-drain, discarding all state.
- Effective dirty bits: EffDirty = DirtyVector with bit WritebackAddr cleared when WritebackValid=1. A writeback in the same cycle unblocks a dependent instruction with no bubble.
- Hazard is the OR of:
  - DecRegAReadEn and EffDirty[DecRegAAddr];
  - DecRegBReadEn and EffDirty[DecRegBAddr];
  - DecRegAWriteEn and EffDirty[DecRegAAddr] (WAW).
  - Address 0 never causes a hazard.
- FU check: fu_ok = (DecFUEnable==0) or |(DecFUEnable & FUReady).
- InstrReady = (state==RUN) && ~hazard && fu_ok. InstrReady is combinational and does not depend on InstrValid.
- Accept = InstrValid && InstrReady.
- Issue, for an accepted instruction with DecHaltEn=0:
  - next cycle IssueValid=1 and IssueFUEnable=DecFUEnable;
  - otherwise IssueValid=0 and IssueFUEnable=0;
  - latency is 1 cycle.
- Dirty set: on an accepted issue with DecDirtyBitTrigger && DecRegAWriteEn && DecRegAAddr!=0, set bit DecRegAAddr. If a set and a writeback clear hit the same bit in the same cycle, the set wins.
- State machine:
  - RUN: an accepted instruction with DecBranchStall=1 goes to BRANCH_WAIT. An accepted instruction with DecHaltEn=1 is consumed without issue (IssueValid stays 0) and goes to DRAIN. Halt takes priority if both flags are set. BranchResolved is ignored in RUN.
  - BRANCH_WAIT: InstrReady=0. On BranchResolved=1, go to RUN; the next instruction may be accepted in the following cycle.
  - DRAIN: InstrReady=0. Writebacks still clear bits. When EffDirty==0, go to HALTED; if already clean on entry, go the next cycle.
  - HALTED: Halted=1 and InstrReady=0. Sticky until reset.
- StallCycles: +1 each cycle InstrValid=1 && InstrReady=0 in RUN or BRANCH_WAIT. Saturates at all-ones. Not counted in DRAIN or HALTED.
- Inputs are ignored when InstrValid=0. The decoder only presents decoded fields; the scheduler performs no decoding itself.

Test Plan:
- Dependency stall: issue ALU0 writing r3 (dirty trigger), then ALU1 reading r3 via B. Response: DirtyVector=0x0008; InstrReady=0 and StallCycles increments until WritebackValid=1 with WritebackAddr=3; issue in that same cycle; IssueValid one cycle later with IssueFUEnable=5'b00010.
- Same-cycle set and clear: writeback r5 while issuing a new write to r5. Response: bit 5 remains 1. Writes to r0 never set bit 0.
- FU busy: DecFUEnable=5'b01000, FUReady=5'b10111. Response: InstrReady=0. Raise FUReady[3]; accept; IssueFUEnable=5'b01000 next cycle. DecFUEnable=0 is accepted with FUReady=0.
- Branch: accept DecBranchStall=1. Response: InstrReady=0 for 4 cycles with InstrValid=1 and StallCycles=4; pulse BranchResolved; next instruction accepted the following cycle.
- Halt with r2 and r7 dirty: accept halt. Response: no IssueValid; state DRAIN; writeback r2 then r7; Halted=1 the cycle after the r7 writeback. Hold StallCycles near all-ones in RUN to check saturation.
- Reset mid-operation: rst=0 during BRANCH_WAIT with DirtyVector=0x00F0. Response: all outputs 0 after the edge; state RUN; InstrReady=1 for a hazard-free instruction.
